// File: rtl/int_sequencer.sv
// Interrupt/reset entry sequencer for the 6502 datapath: arbitrates RESET, NMI,
// BRK and IRQ and strobes the control unit through pushes, vector fetch and I-set.
module int_sequencer #(
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] RES_VEC     = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready,
  input  logic        boundary,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        i_flag,
  output logic        busy,
  output logic [1:0]  cause,
  output logic        push_en,
  output logic [1:0]  push_sel,
  output logic        stack_dummy,
  output logic        b_flag,
  output logic        vec_fetch_en,
  output logic [15:0] vec_addr,
  output logic        pc_ld_l,
  output logic        pc_ld_h,
  output logic        set_i,
  output logic        done
);

  // state   | meaning
  // IDLE    | waiting for a request at an opcode boundary
  // DUM1..3 | reset: dummy stack decrements, no writes
  // PUSH_H  | push PCH
  // PUSH_L  | push PCL
  // PUSH_P  | push P (B set only for BRK)
  // VEC_LO  | fetch vector low byte into PCL, set I
  // VEC_HI  | fetch vector high byte into PCH
  // DONE    | one-cycle completion pulse
  typedef enum logic [3:0] {
    S_IDLE, S_DUM1, S_DUM2, S_DUM3, S_PUSH_H, S_PUSH_L, S_PUSH_P,
    S_VEC_LO, S_VEC_HI, S_DONE
  } state_t;

  localparam logic [1:0] C_RESET = 2'd0;
  localparam logic [1:0] C_NMI   = 2'd1;
  localparam logic [1:0] C_BRK   = 2'd2;
  localparam logic [1:0] C_IRQ   = 2'd3;

  state_t                 state_q, state_d;
  logic [1:0]             cause_q, cause_d;
  logic                   nmi_pend_q, nmi_pend_d;
  logic                   nmi_edge_q, nmi_edge_d;
  logic                   nmi_prev_q, nmi_prev_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic                   edge_now;
  logic                   nmi_seen;
  logic                   irq_act;
  logic [15:0]            vec_base;

  assign nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
  assign irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], irq_n};
  assign nmi_prev_d = nmi_sync_q[SYNC_STAGES-1];
  assign edge_now   = nmi_prev_q & ~nmi_sync_q[SYNC_STAGES-1];
  assign nmi_seen   = nmi_pend_q | nmi_edge_q | edge_now;
  assign irq_act    = ~irq_sync_q[SYNC_STAGES-1] & ~i_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DUM1;
      cause_q    <= C_RESET;
      nmi_pend_q <= 1'b0;
      nmi_edge_q <= 1'b0;
      nmi_prev_q <= 1'b1;
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_edge_q <= nmi_edge_d;
      nmi_prev_q <= nmi_prev_d;
      nmi_sync_q <= nmi_sync_d;
      irq_sync_q <= irq_sync_d;
    end
  end

  // While stalled, a detected NMI edge is parked in nmi_edge_q so it is not lost.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    nmi_pend_d = nmi_pend_q;
    nmi_edge_d = nmi_edge_q | edge_now;
    if (ready) begin
      nmi_edge_d = 1'b0;
      nmi_pend_d = nmi_seen;
      case (state_q)
        S_IDLE: begin
          if (boundary) begin
            if (nmi_seen) begin
              cause_d = C_NMI;
              state_d = S_PUSH_H;
            end else if (brk_req) begin
              cause_d = C_BRK;
              state_d = S_PUSH_H;
            end else if (irq_act) begin
              cause_d = C_IRQ;
              state_d = S_PUSH_H;
            end
          end
        end
        S_DUM1:   state_d = S_DUM2;
        S_DUM2:   state_d = S_DUM3;
        S_DUM3:   state_d = S_VEC_LO;
        S_PUSH_H: state_d = S_PUSH_L;
        S_PUSH_L: state_d = S_PUSH_P;
        S_PUSH_P: begin
          state_d = S_VEC_LO;
          // late NMI hijacks a BRK/IRQ entry; the pushed B bit is already gone
          if (nmi_seen) cause_d = C_NMI;
          if (cause_d == C_NMI) nmi_pend_d = 1'b0;
        end
        S_VEC_LO: state_d = S_VEC_HI;
        S_VEC_HI: state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (cause_q)
      C_RESET: vec_base = RES_VEC;
      C_NMI:   vec_base = NMI_VEC;
      default: vec_base = IRQ_VEC;
    endcase
    busy         = (state_q != S_IDLE);
    cause        = cause_q;
    push_en      = 1'b0;
    push_sel     = 2'd0;
    stack_dummy  = 1'b0;
    b_flag       = 1'b0;
    vec_fetch_en = 1'b0;
    vec_addr     = 16'h0000;
    pc_ld_l      = 1'b0;
    pc_ld_h      = 1'b0;
    set_i        = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_DUM1, S_DUM2, S_DUM3: stack_dummy = 1'b1;
      S_PUSH_H: push_en = 1'b1;
      S_PUSH_L: begin
        push_en  = 1'b1;
        push_sel = 2'd1;
      end
      S_PUSH_P: begin
        push_en  = 1'b1;
        push_sel = 2'd2;
        b_flag   = (cause_q == C_BRK);
      end
      S_VEC_LO: begin
        vec_fetch_en = 1'b1;
        vec_addr     = vec_base;
        pc_ld_l      = 1'b1;
        set_i        = 1'b1;
      end
      S_VEC_HI: begin
        vec_fetch_en = 1'b1;
        vec_addr     = vec_base + 16'd1;
        pc_ld_h      = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
